// File: rtl/hazard_forward_unit_if.sv
// Decode-side bus of the hazard/forwarding unit.
// The decoder (master) presents the instruction being decoded and its operand
// reads. It receives the operand/flag forward selects and the stall request.
//   issue_*      : destination/result-source description of the decode instr
//   read_*/use_* : operand registers and whether they are really read
//   uses_flags   : decode instr is a conditional branch
//   flush        : taken branch kills the decode instr
//   fw_a/fw_b    : 0 = register file, k = forward from stage k
//   flag_fw      : 0 = architectural flags, k = flags from stage k
//   stall        : hold PC and IF/ID
//   stall_count  : saturating count of stalled cycles
interface hazard_forward_unit_if #(
   parameter int STG_W = 2
);
   logic             issue_valid;
   logic [4:0]       issue_rd;
   logic             issue_regwrite;
   logic [1:0]       issue_src;
   logic             issue_setflag;
   logic [4:0]       read_a;
   logic [4:0]       read_b;
   logic             use_a;
   logic             use_b;
   logic             uses_flags;
   logic             flush;
   logic [STG_W-1:0] fw_a;
   logic [STG_W-1:0] fw_b;
   logic [STG_W-1:0] flag_fw;
   logic             stall;
   logic [15:0]      stall_count;

   modport master (
      output issue_valid, issue_rd, issue_regwrite, issue_src, issue_setflag,
             read_a, read_b, use_a, use_b, uses_flags, flush,
      input  fw_a, fw_b, flag_fw, stall, stall_count
   );

   modport slave (
      input  issue_valid, issue_rd, issue_regwrite, issue_src, issue_setflag,
             read_a, read_b, use_a, use_b, uses_flags, flush,
      output fw_a, fw_b, flag_fw, stall, stall_count
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding unit for the decode stage.
// Tracks in-flight writers in a shift-register scoreboard (stage 1 = EX,
// increasing toward WB) and derives the nearest-producer forward selects for
// both operands and the flags, plus a stall when the nearest producer of a
// read operand has not yet produced its result (load / multi-cycle MUL).
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-low
//   bus   : decode-side bus (slave modport), see hazard_forward_unit_if
module hazard_forward_unit #(
   parameter int PIPE_DEPTH = 3,
   parameter int MEM_STAGE  = 2,
   parameter int MUL_STAGE  = 3,
   parameter int STG_W      = $clog2(PIPE_DEPTH + 1)
) (
   input logic                  clk,
   input logic                  reset,
   hazard_forward_unit_if.slave bus
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic [1:0] src;
      logic       setflag;
   } entry_t;

   entry_t [PIPE_DEPTH:1] sb_q, sb_d;
   logic [15:0]           stall_count_q, stall_count_d;

   logic [STG_W-1:0] fw_a_c, fw_b_c, flag_fw_c;
   logic             rdy_a, rdy_b, stall_c;

   // First stage at which a producer's result exists on a bypass path.
   function automatic logic src_ready(input logic [1:0] src, input int stg);
      logic r;
      case (src)
         2'b11:   r = (stg >= MEM_STAGE);
         2'b10:   r = (stg >= MUL_STAGE);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // Scanning from the oldest stage down leaves the nearest match standing.
   always_comb begin
      fw_a_c    = '0;
      fw_b_c    = '0;
      flag_fw_c = '0;
      rdy_a     = 1'b1;
      rdy_b     = 1'b1;
      for (int k = PIPE_DEPTH; k >= 1; k--) begin
         if (sb_q[k].valid && sb_q[k].regwrite && bus.use_a &&
             bus.read_a != 5'd31 && sb_q[k].rd == bus.read_a) begin
            fw_a_c = STG_W'(k);
            rdy_a  = src_ready(sb_q[k].src, k);
         end
         if (sb_q[k].valid && sb_q[k].regwrite && bus.use_b &&
             bus.read_b != 5'd31 && sb_q[k].rd == bus.read_b) begin
            fw_b_c = STG_W'(k);
            rdy_b  = src_ready(sb_q[k].src, k);
         end
         if (bus.uses_flags && sb_q[k].valid && sb_q[k].setflag)
            flag_fw_c = STG_W'(k);
      end
      stall_c = bus.issue_valid && !bus.flush && !(rdy_a && rdy_b);
   end

   always_comb begin
      sb_d[1] = '0;
      if (bus.issue_valid && !stall_c && !bus.flush) begin
         sb_d[1].valid    = 1'b1;
         sb_d[1].rd       = bus.issue_rd;
         sb_d[1].regwrite = bus.issue_regwrite;
         sb_d[1].src      = bus.issue_src;
         sb_d[1].setflag  = bus.issue_setflag;
      end
      for (int k = 2; k <= PIPE_DEPTH; k++)
         sb_d[k] = sb_q[k-1];

      stall_count_d = stall_count_q;
      if (stall_c && stall_count_q != 16'hFFFF)
         stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sb_q          <= '0;
         stall_count_q <= '0;
      end else begin
         sb_q          <= sb_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.fw_a        = fw_a_c;
   assign bus.fw_b        = fw_b_c;
   assign bus.flag_fw     = flag_fw_c;
   assign bus.stall       = stall_c;
   assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
   localparam int PD   = 3;
   localparam int MEMS = 2;
   localparam int MULS = 3;
   localparam int SW   = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hazard_forward_unit_if #(.STG_W(SW)) bus ();

   hazard_forward_unit #(
      .PIPE_DEPTH(PD), .MEM_STAGE(MEMS), .MUL_STAGE(MULS), .STG_W(SW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // Reference model: list of issued instructions with the cycle they entered
   // stage 1; stage = cycles elapsed since then + 1.
   typedef struct {
      logic [4:0] rd;
      bit         rw;
      logic [1:0] src;
      bit         sf;
      int         born;
   } rec_t;

   typedef struct {
      int fa, fb, ff;
      int st;
      int cnt;
   } exp_t;

   rec_t inflight[$];
   exp_t expq[$];
   int   cyc = 0;
   int   mcount = 0;
   bit   last_stall = 0;
   int   tests = 0;
   int   fails = 0;

   // staged stimulus
   logic       s_iv, s_rw, s_sf, s_ua, s_ub, s_uf, s_fl, s_rst;
   logic [4:0] s_rd, s_ra, s_rb;
   logic [1:0] s_src;

   function automatic int need(input logic [1:0] s);
      if (s == 2'b11) return MEMS;
      if (s == 2'b10) return MULS;
      return 1;
   endfunction

   function automatic void operand(input logic [4:0] r, input logic u,
                                   output int sel, output bit blk);
      int best = PD + 1;
      logic [1:0] bsrc = 2'b00;
      foreach (inflight[i]) begin
         int stg = cyc - inflight[i].born + 1;
         if (inflight[i].rw && u && r != 5'd31 && inflight[i].rd == r && stg < best) begin
            best = stg;
            bsrc = inflight[i].src;
         end
      end
      sel = 0;
      blk = 0;
      if (best <= PD) begin
         sel = best;
         blk = (best < need(bsrc));
      end
   endfunction

   function automatic exp_t compute_exp();
      exp_t e;
      bit ba, bb;
      int best = PD + 1;
      operand(bus.read_a, bus.use_a, e.fa, ba);
      operand(bus.read_b, bus.use_b, e.fb, bb);
      foreach (inflight[i]) begin
         int stg = cyc - inflight[i].born + 1;
         if (inflight[i].sf && stg < best) best = stg;
      end
      e.ff  = (bus.uses_flags && best <= PD) ? best : 0;
      e.st  = (bus.issue_valid && !bus.flush && (ba || bb)) ? 1 : 0;
      e.cnt = mcount;
      return e;
   endfunction

   function automatic void model_edge();
      bit take = reset && bus.issue_valid && !last_stall && !bus.flush;
      if (!reset) begin
         inflight.delete();
         mcount = 0;
      end else if (last_stall && mcount != 65535) begin
         mcount++;
      end
      cyc++;
      for (int i = inflight.size() - 1; i >= 0; i--)
         if (cyc - inflight[i].born + 1 > PD) inflight.delete(i);
      if (take)
         inflight.push_back('{rd: bus.issue_rd, rw: bus.issue_regwrite,
                              src: bus.issue_src, sf: bus.issue_setflag, born: cyc});
   endfunction

   task automatic apply();
      reset              = s_rst;
      bus.issue_valid    = s_iv;
      bus.issue_rd       = s_rd;
      bus.issue_regwrite = s_rw;
      bus.issue_src      = s_src;
      bus.issue_setflag  = s_sf;
      bus.read_a         = s_ra;
      bus.read_b         = s_rb;
      bus.use_a          = s_ua;
      bus.use_b          = s_ub;
      bus.uses_flags     = s_uf;
      bus.flush          = s_fl;
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      model_edge();
      #1;
      apply();
      #0;
      e = compute_exp();
      last_stall = (e.st != 0);
      expq.push_back(e);
   endtask

   task automatic idle();
      s_iv = 0; s_rd = 0; s_rw = 0; s_src = 0; s_sf = 0;
      s_ra = 0; s_rb = 0; s_ua = 0; s_ub = 0; s_uf = 0; s_fl = 0; s_rst = 1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [1:0] src, input logic sf);
      s_iv = 1; s_rd = rd; s_rw = 1; s_src = src; s_sf = sf;
   endtask

   task automatic do_reset();
      idle();
      s_rst = 0;
      tick();
      idle();
   endtask

   function automatic void chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: outputs are combinational, so each cycle's expected response is
   // compared mid-cycle once the stimulus has settled.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         chk("fw_a", int'(bus.fw_a), e.fa);
         chk("fw_b", int'(bus.fw_b), e.fb);
         chk("flag_fw", int'(bus.flag_fw), e.ff);
         chk("stall", int'(bus.stall), e.st);
         chk("stall_count", int'(bus.stall_count), e.cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      s_rst = 0;
      apply();
      do_reset();

      // forwarding from ALU producer at stages 1 and 2
      issue(5'd1, 2'b01, 0); tick();
      issue(5'd9, 2'b01, 0); s_ra = 1; s_ua = 1; tick();
      idle(); s_ra = 1; s_ua = 1; tick();
      idle(); tick();

      // load-use: one stall cycle
      do_reset();
      issue(5'd2, 2'b11, 0); tick();
      issue(5'd6, 2'b01, 0); s_rb = 2; s_ub = 1; tick(); tick();
      idle(); tick();

      // MUL: two stall cycles
      do_reset();
      issue(5'd4, 2'b10, 0); tick();
      issue(5'd7, 2'b01, 0); s_ra = 4; s_ua = 1; tick(); tick(); tick();
      idle(); tick();

      // nearest producer wins; flags
      do_reset();
      issue(5'd3, 2'b01, 0); tick();
      issue(5'd3, 2'b01, 1); tick();
      issue(5'd8, 2'b01, 1); s_ra = 3; s_rb = 3; s_ua = 1; s_ub = 1; tick();
      idle(); s_iv = 1; s_uf = 1; tick();
      idle(); s_uf = 1; tick(); tick(); tick();

      // X31 and unused operand
      do_reset();
      issue(5'd31, 2'b01, 0); tick();
      idle(); s_iv = 1; s_ra = 31; s_ua = 1; tick();
      issue(5'd7, 2'b11, 0); tick();
      idle(); s_iv = 1; s_ra = 7; s_ua = 0; tick();

      // flush beats stall; reset mid-stall
      do_reset();
      issue(5'd5, 2'b11, 0); tick();
      issue(5'd10, 2'b01, 0); s_ra = 5; s_ua = 1; s_fl = 1; tick();
      s_fl = 0; tick(); tick();
      idle(); tick();
      issue(5'd4, 2'b10, 0); tick();
      issue(5'd11, 2'b01, 0); s_ra = 4; s_ua = 1; tick();
      s_rst = 0; tick();
      s_rst = 1; tick();
      idle(); tick();

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         s_iv  = ($urandom % 4) != 0;
         s_rd  = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         s_rw  = ($urandom % 5) != 0;
         s_src = 2'($urandom % 4);
         s_sf  = ($urandom % 3) == 0;
         s_ra  = ($urandom % 10 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         s_rb  = 5'($urandom_range(0, 7));
         s_ua  = ($urandom % 4) != 0;
         s_ub  = ($urandom % 3) != 0;
         s_uf  = ($urandom % 3) == 0;
         s_fl  = ($urandom % 8) == 0;
         s_rst = ($urandom % 70) != 0;
         tick();
      end
      idle();
      tick();

      repeat (3) @(negedge clk);
      if (expq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d responses unchecked, expected 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the single-cycle-lookback forwarding logic in the pipelined CPU's decode stage.
- Keeps a shift-register scoreboard of in-flight writers, one entry per downstream stage (1 = EX, increasing toward WB). Sized by PIPE_DEPTH, with a per-producer-type result-ready stage.
- Outputs per-operand and flag forward selects, plus a load-use/multi-cycle-MUL stall. Selects always choose the nearest producer.
- Sits beside the decoder and drives the operand muxes and the PC/IF-ID hold.

Parameters:
PIPE_DEPTH, 3, number of tracked downstream stages; entries occupy stages 1..PIPE_DEPTH.
MEM_STAGE, 2, first stage at which a load (src 11) result can be forwarded; 1..PIPE_DEPTH.
MUL_STAGE, 3, first stage at which a MUL (src 10) result can be forwarded; 1..PIPE_DEPTH.
STG_W, $clog2(PIPE_DEPTH+1), width of the stage-select outputs.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
issue_valid  in  1  decode holds a real instruction.
issue_rd  in  5  destination register of decode instruction.
issue_regwrite  in  1  decode instruction writes issue_rd.
issue_src  in  2  result source: 00 shift, 01 ALU, 10 MUL, 11 MEM.
issue_setflag  in  1  decode instruction updates flags.
read_a  in  5  operand A register.
read_b  in  5  operand B register.
use_a  in  1  operand A is actually read.
use_b  in  1  operand B is actually read.
uses_flags  in  1  decode instruction is B.cond.
flush  in  1  taken branch: kill the decode instruction.
fw_a  out  STG_W  0 = register file, k = forward from stage k.
fw_b  out  STG_W  same for operand B.
flag_fw  out  STG_W  0 = architectural flags, k = flags from stage k.
stall  out  1  hold PC and IF/ID; decode instruction not issued.
stall_count  out  16  saturating count of stalled cycles.

Behaviour:
- Scoreboard
  - Entry per stage: valid, rd[4:0], regwrite, src[1:0], setflag.
  - Each clock, entry k moves to k+1; entry PIPE_DEPTH is dropped.
  - Stage 1 loads the decode instruction only if issue_valid & !stall & !flush. Otherwise stage 1 loads a bubble (valid=0).
- Operand match for operand A (B identical with read_b/use_b/fw_b)
  - A stage k matches when: valid & regwrite & rd==read_a & read_a!=31 & use_a.
  - Lowest k wins. fw_a = that k, else 0.
  - X31 never matches and never stalls.
- Readiness
  - src 00/01 is ready at k>=1.
  - src 11 is ready at k>=MEM_STAGE.
  - src 10 is ready at k>=MUL_STAGE.
  - Only the nearest match is checked; older matches are ignored.
- stall (combinational)
  - Asserted when issue_valid & !flush and the nearest match for A or B is not ready.
  - While stalled, fw_a/fw_b still report the nearest stage.
  - Bubbles advance the producer, so stall drops automatically. Load at MEM_STAGE=2: exactly 1 stall cycle. MUL at MUL_STAGE=3: 2 cycles.
- flag_fw
  - Set only when uses_flags: lowest k with valid & setflag, else 0.
  - Flags are ready at k>=1, so flags never stall.
- flush
  - Forces stall=0 and inserts a bubble.
  - Does not clear entries already in stages >=1.
- Flush and stall conditions together: flush wins.
- stall_count: +1 on every cycle with stall=1, saturates at 16'hFFFF.
- Reset (reset==0 at a clock edge)
  - All entries invalid and stall_count=0.
  - On the following cycle fw_a=fw_b=flag_fw=0 and stall=0 (no valid entries).
  - Reset taken mid-stall abandons the stall.
- Combinational outputs have zero latency relative to the current scoreboard contents.

Test Plan:
Defaults (PIPE_DEPTH=3, MEM_STAGE=2, MUL_STAGE=3) apply to all scenarios below.
1. Issue ADDI X1 (src 01), then next cycle read_a=1,use_a=1 -> fw_a=1, stall=0; one cycle later (other instr between) fw_a=2.
2. Issue LDUR X2 (src 11), next cycle read_b=2,use_b=1 -> stall=1 for exactly 1 cycle, then fw_b=2, stall=0; stall_count=1.
3. Issue MUL X4 (src 10), next read_a=4 -> stall=1 for 2 cycles, then fw_a=3; stall_count=2.
4. ADDI X3 then ADDS X3 back-to-back, then read_a=3,read_b=3 -> fw_a=fw_b=1 (nearest); then SUBS (setflag) in stage 1 with uses_flags=1 -> flag_fw=1.
5. ADDI X31 then read_a=31 -> fw_a=0, stall=0; same with use_a=0 and read_a matching -> fw_a=0.
6. LDUR X5 then read X5 (stall=1) with flush=1 same cycle -> stall=0, bubble inserted. Separately, reset=0 during a MUL stall -> next cycle stall=0, all fw=0, stall_count=0.
